// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter: data side has priority, a streak limit keeps fetch moving,
// and a watchdog aborts hung accesses. Optional grant/stall counters under ARB_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int D_STREAK_MAX = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              bus_err,
    output logic [31:0]       igrant_cnt,
    output logic [31:0]       dgrant_cnt,
    output logic [31:0]       stall_cnt
);

    localparam int STREAK_W = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(D_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t              state_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic [31:0]         timer_reg;
    logic                ram_ren_reg;
    logic                ram_wen_reg;
    logic [ADDR_W-1:0]   ram_addr_reg;
    logic [DATA_W-1:0]   ram_store_reg;

    logic d_req;
    logic d_pick;
    logic in_acc;
    logic timeout_hit;
    logic finish;

    assign d_req  = dREN | dWEN;
    assign d_pick = d_req && !(iREN && (streak_reg == STREAK_LIM));
    assign in_acc = (state_reg != IDLE);

    generate
        if (TIMEOUT_CYC == 0) begin : g_no_wdog
            assign timeout_hit = 1'b0;
        end else begin : g_wdog
            // A same-cycle ready beats the abort.
            assign timeout_hit = in_acc && !ram_ready && (timer_reg == 32'(TIMEOUT_CYC - 1));
        end
    endgenerate

    assign finish  = (in_acc && ram_ready) || timeout_hit;
    assign bus_err = timeout_hit;

    assign iwait = iREN  && !((state_reg == IACC) && finish);
    assign dwait = d_req && !((state_reg == DACC) && finish);
    assign iload = ((state_reg == IACC) && ram_ready) ? ram_load : '0;
    assign dload = ((state_reg == DACC) && ram_ready) ? ram_load : '0;

    assign ram_ren   = ram_ren_reg;
    assign ram_wen   = ram_wen_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_store = ram_store_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            timer_reg     <= '0;
            ram_ren_reg   <= 1'b0;
            ram_wen_reg   <= 1'b0;
            ram_addr_reg  <= '0;
            ram_store_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (d_pick) begin
                        state_reg     <= DACC;
                        timer_reg     <= '0;
                        ram_ren_reg   <= !dWEN;
                        ram_wen_reg   <= dWEN;
                        ram_addr_reg  <= daddr;
                        ram_store_reg <= dstore;
                        if (!iREN)
                            streak_reg <= '0;
                        else if (streak_reg != STREAK_LIM)
                            streak_reg <= streak_reg + 1'b1;
                    end else if (iREN) begin
                        state_reg     <= IACC;
                        timer_reg     <= '0;
                        ram_ren_reg   <= 1'b1;
                        ram_wen_reg   <= 1'b0;
                        ram_addr_reg  <= iaddr;
                        ram_store_reg <= '0;
                        streak_reg    <= '0;
                    end
                end
                IACC, DACC: begin
                    if (finish) begin
                        state_reg   <= IDLE;
                        ram_ren_reg <= 1'b0;
                        ram_wen_reg <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    ram_ren_reg <= 1'b0;
                    ram_wen_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Index 0: I grants, 1: D grants, 2: stall cycles.
    logic [31:0] cnt_reg [3];
    logic [2:0]  cnt_inc;

    assign cnt_inc[0] = (state_reg == IDLE) && !d_pick && iREN;
    assign cnt_inc[1] = (state_reg == IDLE) && d_pick;
    assign cnt_inc[2] = iwait | dwait;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi])
                    cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
            end
        end
    endgenerate

    assign igrant_cnt = cnt_reg[0];
    assign dgrant_cnt = cnt_reg[1];
    assign stall_cnt  = cnt_reg[2];
`else
    assign igrant_cnt = '0;
    assign dgrant_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a monitor
// pops them whenever a requester's wait drops.
module tb_mem_arbiter;

    localparam logic [31:0] K = 32'h8C010044;  // RAM model: load = addr ^ K

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ram_ren, ram_wen, ram_ready, bus_err;
    logic [31:0] ram_addr, ram_store, ram_load;
    logic [31:0] igrant_cnt, dgrant_cnt, stall_cnt;

    int tests = 0;
    int fails = 0;
    int ready_delay = 1;
    int acc_cyc = 0;

    typedef struct {
        bit          is_d;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_STREAK_MAX(4), .TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .bus_err(bus_err),
        .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .stall_cnt(stall_cnt)
    );

    // RAM model: ready on the ready_delay-th strobe cycle, never when ready_delay==0.
    always @(posedge CLK) acc_cyc <= (ram_ren | ram_wen) ? acc_cyc + 1 : 0;
    assign ram_ready = (ram_ren | ram_wen) && (ready_delay != 0) && (acc_cyc == ready_delay - 1);
    assign ram_load  = ram_addr ^ K;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic push(input bit is_d, input bit chk, input logic [31:0] data, input bit err);
        exp_t e;
        e.is_d = is_d; e.chk_data = chk; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic handle(input bit is_d, input logic [31:0] load);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_completion", {31'd0, is_d}, 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            check(is_d ? "mon_side_d" : "mon_side_i", {31'd0, is_d}, {31'd0, e.is_d});
            if (e.chk_data) check("mon_load", load, e.data);
            check("mon_bus_err", {31'd0, bus_err}, {31'd0, e.err});
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (iREN && !iwait) handle(1'b0, iload);
            if ((dREN || dWEN) && !dwait) handle(1'b1, dload);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        repeat (2) @(negedge CLK);
        check("rst_iwait", {31'd0, iwait}, 32'd1);
        check("rst_dwait", {31'd0, dwait}, 32'd0);
        check("rst_ram_ren", {31'd0, ram_ren}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_counters", igrant_cnt | dgrant_cnt | stall_cnt, 32'd0);
        iREN = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        cyc();

        // Solo I fetch, ready on first IACC cycle
        ready_delay = 1;
        iREN = 1'b1; iaddr = 32'h40;
        push(1'b0, 1'b1, 32'h8C010004, 1'b0);
        smp();
        check("soloI_c1_iwait", {31'd0, iwait}, 32'd1);
        check("soloI_c1_ren", {31'd0, ram_ren}, 32'd0);
        cyc(); smp();
        check("soloI_c2_iwait", {31'd0, iwait}, 32'd0);
        check("soloI_c2_ren", {31'd0, ram_ren}, 32'd1);
        check("soloI_c2_addr", ram_addr, 32'h40);
        cyc(); iREN = 1'b0;
        cyc();

        // Contention: expected order D,D,D,D,I,D,D,D,D,I
        ready_delay = 1;
        iaddr = 32'h80; daddr = 32'h200;
        for (int n = 0; n < 10; n++) begin
            if (n == 4 || n == 9) push(1'b0, 1'b1, 32'h8C0100C4, 1'b0);
            else                  push(1'b1, 1'b1, 32'h8C010244, 1'b0);
        end
        iREN = 1'b1; dREN = 1'b1;
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            @(negedge CLK); #1;
        end
        check("contend_drained", sb.size(), 32'd0);
        @(posedge CLK); #1; iREN = 1'b0; dREN = 1'b0;
        sb.delete();
        cyc();

        // Write, ready in third DACC cycle
        ready_delay = 3;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        push(1'b1, 1'b0, 32'h0, 1'b0);
        smp();
        check("wr_c1_wen", {31'd0, ram_wen}, 32'd0);
        check("wr_c1_dwait", {31'd0, dwait}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            cyc(); smp();
            check("wr_wen", {31'd0, ram_wen}, 32'd1);
            check("wr_ren", {31'd0, ram_ren}, 32'd0);
            check("wr_addr", ram_addr, 32'h100);
            check("wr_store", ram_store, 32'hDEADBEEF);
            check("wr_dwait", {31'd0, dwait}, (c == 3) ? 32'd0 : 32'd1);
        end
        cyc(); dWEN = 1'b0; smp();
        check("wr_idle_wen", {31'd0, ram_wen}, 32'd0);
        cyc();

        // Read+write together behaves as a write
        ready_delay = 1;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h104;
        push(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(); smp();
        check("rw_wen", {31'd0, ram_wen}, 32'd1);
        check("rw_ren", {31'd0, ram_ren}, 32'd0);
        cyc(); dREN = 1'b0; dWEN = 1'b0;
        cyc();

        // Watchdog: never ready, abort in 8th DACC cycle
        ready_delay = 0;
        dREN = 1'b1; daddr = 32'h300;
        push(1'b1, 1'b1, 32'h0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            cyc(); smp();
            check("to_bus_err", {31'd0, bus_err}, (c == 8) ? 32'd1 : 32'd0);
            check("to_dwait", {31'd0, dwait}, (c == 8) ? 32'd0 : 32'd1);
        end
        cyc(); dREN = 1'b0; smp();
        check("to_idle_ren", {31'd0, ram_ren}, 32'd0);
        check("to_idle_bus_err", {31'd0, bus_err}, 32'd0);
        cyc();

        // Reset mid-DACC drops strobes at once
        ready_delay = 0;
        dREN = 1'b1; daddr = 32'h400;
        cyc(); smp();
        check("ab_ren_before", {31'd0, ram_ren}, 32'd1);
        @(posedge CLK); #2; nRST = 1'b0; #1;
        check("ab_ren_in_rst", {31'd0, ram_ren}, 32'd0);
        check("ab_wen_in_rst", {31'd0, ram_wen}, 32'd0);
        dREN = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        cyc();

        // Ten alternating accesses for the counters
        ready_delay = 1;
        for (int k = 0; k < 10; k++) begin
            iREN = 1'b0; dREN = 1'b0;
            if (k % 2 == 0) begin
                iaddr = 32'h500 + 32'(k * 4); iREN = 1'b1;
                push(1'b0, 1'b1, (32'h500 + 32'(k * 4)) ^ K, 1'b0);
            end else begin
                daddr = 32'h600 + 32'(k * 4); dREN = 1'b1;
                push(1'b1, 1'b1, (32'h600 + 32'(k * 4)) ^ K, 1'b0);
            end
            cyc(); cyc();
        end
        iREN = 1'b0; dREN = 1'b0;
        smp();
`ifdef ARB_STATS_EN
        check("stats_grant_sum", igrant_cnt + dgrant_cnt, 32'd10);
        check("stats_igrant", igrant_cnt, 32'd5);
        check("stats_stall", stall_cnt, 32'd10);
`else
        check("stats_off_zero", igrant_cnt | dgrant_cnt | stall_cnt, 32'd0);
`endif
        cyc();
        check("sb_final_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
